// File: rtl/store_logic_gen.sv
// -----------------------------------------------------------------------------
// store_logic_gen
//
// Purpose:
//   Streams one tile of result words into a block RAM write port.
//   When start_store is seen in IDLE, the tile length (32 or 512 words) and the
//   destination base address are latched:
//     tile_base = base(Buffer_Select) + (Double_buffering ? DB_OFFSET : 0)
//               + tile_ptr * tile_len        (truncated to ADDR_WIDTH)
//   Each accepted beat (in_valid && in_ready) is written one cycle later at
//   tile_base + beat_cnt.
//   tile_ptr advances once per completed tile, so consecutive tiles land in
//   consecutive regions.
//
// Ports:
//   clk                 system clock
//   rst_n               asynchronous active-low reset
//   start_store         pulse, begins one tile (ignored unless idle)
//   reset_addr_counter  pulse, clears the tile pointer (any state)
//   Buffer_Select[3:0]  destination buffer code (1xxx is illegal -> sel_err)
//   Tiles_Control       1: 32-word tile, 0: 512-word tile
//   Double_buffering    adds DB_OFFSET to the destination base
//   in_valid / in_data  result word stream
//   in_ready            high while a tile is being stored
//   bram_addr/_wdata    registered BRAM write address / data
//   bram_en / bram_we   registered BRAM enable / write enable
//   store_done          one-cycle pulse, coincident with the last BRAM write
//   busy                high while storing or finishing a tile
//   sel_err             sticky illegal Buffer_Select flag (cleared by reset)
// -----------------------------------------------------------------------------
module store_logic_gen #(
  parameter int ADDR_WIDTH       = 16,
  parameter int ORIGINAL_COLUMNS = 768,
  parameter int ORIGINAL_ROWS    = 512,
  parameter int NUM_BITS         = 8,
  parameter int DATA_WIDTH       = 256,
  parameter int DB_OFFSET        = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_store,
  input  logic                  reset_addr_counter,
  input  logic [3:0]            Buffer_Select,
  input  logic                  Tiles_Control,
  input  logic                  Double_buffering,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wdata,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic                  store_done,
  output logic                  busy,
  output logic                  sel_err
);

  // Words occupied by one full quantized matrix.
  localparam int MAT_WORDS = ORIGINAL_COLUMNS * ORIGINAL_ROWS * NUM_BITS / DATA_WIDTH;

  // Destination base addresses, kept 32 bits wide until the final truncation.
  localparam logic [31:0] BASE_Q   = 32'd0;
  localparam logic [31:0] BASE_K   = 32'(MAT_WORDS);
  localparam logic [31:0] BASE_V   = 32'(2 * MAT_WORDS);
  localparam logic [31:0] BASE_KTQ = 32'd8192;
  localparam logic [31:0] BASE_SV  = 32'd20480;
  localparam logic [31:0] BASE_H   = 32'd28672;
  localparam logic [31:0] BASE_FFN = 32'd0;
  localparam logic [31:0] BASE_O   = 32'd49152;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STORING = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;

  logic [9:0]              tile_ptr_reg;
  logic [9:0]              beat_cnt_reg;
  logic [9:0]              tile_last_reg;    // tile_len - 1 of the tile in progress
  logic [ADDR_WIDTH-1:0]   tile_base_reg;
  logic [ADDR_WIDTH-1:0]   bram_addr_reg;
  logic [DATA_WIDTH-1:0]   bram_wdata_reg;
  logic                    bram_en_reg;
  logic                    sel_err_reg;

  logic [31:0]             sel_base;
  logic [31:0]             tile_len_words;
  logic [31:0]             tile_base_sum;
  logic [ADDR_WIDTH-1:0]   tile_base_next;
  logic [9:0]              tile_last_next;
  logic                    sel_illegal;
  logic                    tile_start;
  logic                    beat_accept;
  logic                    last_beat;

  // Acceptance is derived from the state register rather than from in_ready
  // so the FSM's combinational block does not feed back on itself.
  assign tile_start  = (state_reg == IDLE) && start_store;
  assign beat_accept = (state_reg == STORING) && in_valid;
  assign last_beat   = (beat_cnt_reg == tile_last_reg);

  // ---------------------------------------------------------------------------
  // Destination base for a tile that would start this cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_base    = 32'd0;
    sel_illegal = 1'b0;
    case (Buffer_Select)
      4'b0000: sel_base = BASE_Q;
      4'b0001: sel_base = BASE_K;
      4'b0010: sel_base = BASE_V;
      4'b0011: sel_base = BASE_KTQ;
      4'b0100: sel_base = BASE_SV;
      4'b0101: sel_base = BASE_H;
      4'b0110: sel_base = BASE_FFN;
      4'b0111: sel_base = BASE_O;
      default: begin
        // Unknown buffer: still store the tile (at base 0) so the upstream
        // pipeline never stalls, but flag it.
        sel_base    = 32'd0;
        sel_illegal = 1'b1;
      end
    endcase

    tile_len_words = Tiles_Control ? 32'd32 : 32'd512;
    tile_last_next = Tiles_Control ? 10'd31 : 10'd511;
    tile_base_sum  = sel_base
                   + (Double_buffering ? 32'(DB_OFFSET) : 32'd0)
                   + (32'(tile_ptr_reg) * tile_len_words);
  end

  assign tile_base_next = ADDR_WIDTH'(tile_base_sum);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    busy       = 1'b0;
    store_done = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_store) begin
          state_next = STORING;
        end
      end
      STORING: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (beat_accept && last_beat) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // The last write is on the BRAM port during this cycle.
        busy       = 1'b1;
        store_done = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Tile context: latched at tile start only, so mid-tile changes on
  // Buffer_Select / Tiles_Control / Double_buffering have no effect.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_base_reg <= '0;
      tile_last_reg <= '0;
      beat_cnt_reg  <= '0;
      sel_err_reg   <= 1'b0;
    end else begin
      if (tile_start) begin
        tile_base_reg <= tile_base_next;
        tile_last_reg <= tile_last_next;
        beat_cnt_reg  <= '0;
        if (sel_illegal) begin
          sel_err_reg <= 1'b1;
        end
      end else if (beat_accept) begin
        beat_cnt_reg <= beat_cnt_reg + 10'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tile pointer: a clear request wins over the end-of-tile increment. The
  // pointer only feeds the base of the *next* tile, so clearing it mid-tile
  // leaves the current tile's addresses untouched. Wraps naturally at 1023.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_ptr_reg <= '0;
    end else if (reset_addr_counter) begin
      tile_ptr_reg <= '0;
    end else if (state_reg == DONE) begin
      tile_ptr_reg <= tile_ptr_reg + 10'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // BRAM write port, one cycle behind the accepted beat. Address and data hold
  // their last value when no write is issued.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_addr_reg  <= '0;
      bram_wdata_reg <= '0;
      bram_en_reg    <= 1'b0;
    end else begin
      bram_en_reg <= beat_accept;
      if (beat_accept) begin
        bram_addr_reg  <= tile_base_reg + ADDR_WIDTH'(beat_cnt_reg);
        bram_wdata_reg <= in_data;
      end
    end
  end

  assign bram_addr  = bram_addr_reg;
  assign bram_wdata = bram_wdata_reg;
  assign bram_en    = bram_en_reg;
  assign bram_we    = bram_en_reg;
  assign sel_err    = sel_err_reg;

endmodule

// File: tb/tb_store_logic_gen.sv
// -----------------------------------------------------------------------------
// tb_store_logic_gen
//
// Directed bench for store_logic_gen. Each tile is driven beat by beat; every
// cycle the BRAM port is compared against hand-computed addresses and data
// patterns. One line is printed per tile transaction.
// -----------------------------------------------------------------------------
module tb_store_logic_gen;

  logic         clk;
  logic         rst_n;
  logic         start_store;
  logic         reset_addr_counter;
  logic [3:0]   Buffer_Select;
  logic         Tiles_Control;
  logic         Double_buffering;
  logic         in_valid;
  logic [255:0] in_data;
  logic         in_ready;
  logic [15:0]  bram_addr;
  logic [255:0] bram_wdata;
  logic         bram_en;
  logic         bram_we;
  logic         store_done;
  logic         busy;
  logic         sel_err;

  int checks   = 0;
  int failures = 0;

  store_logic_gen dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start_store        (start_store),
    .reset_addr_counter (reset_addr_counter),
    .Buffer_Select      (Buffer_Select),
    .Tiles_Control      (Tiles_Control),
    .Double_buffering   (Double_buffering),
    .in_valid           (in_valid),
    .in_data            (in_data),
    .in_ready           (in_ready),
    .bram_addr          (bram_addr),
    .bram_wdata         (bram_wdata),
    .bram_en            (bram_en),
    .bram_we            (bram_we),
    .store_done         (store_done),
    .busy               (busy),
    .sel_err            (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] pat(input int idx);
    logic [31:0] w;
    w = 32'h5A5A_0000 + 32'(idx);
    return {8{w}};
  endfunction

  task automatic chk(input string t1, input string t2,
                     input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=%0h expected=%0h", t1, t2, obs, exp);
    end
  endtask

  // Outputs must all sit at their reset values.
  task automatic chk_reset_outputs(input string t1);
    chk(t1, "in_ready",   in_ready,   0);
    chk(t1, "busy",       busy,       0);
    chk(t1, "store_done", store_done, 0);
    chk(t1, "bram_en",    bram_en,    0);
    chk(t1, "bram_we",    bram_we,    0);
    chk(t1, "bram_addr",  bram_addr,  0);
    chk(t1, "bram_wdata", bram_wdata, 0);
    chk(t1, "sel_err",    sel_err,    0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs a whole tile. base is the hand-computed first write address.
  // toggle: in_valid 50% duty; disturb: start_store pulse plus changed
  // selection inputs mid-tile; rac_done: reset_addr_counter during DONE.
  task automatic run_tile(input string name, input logic [3:0] sel,
                          input logic tc, input logic db, input int n,
                          input logic toggle, input logic disturb,
                          input logic rac_done, input int base);
    int   sent;
    int   cyc;
    int   wr_cnt;
    int   exp_addr;
    logic v;
    logic acc;
    Buffer_Select    = sel;
    Tiles_Control    = tc;
    Double_buffering = db;
    start_store      = 1'b1;
    tick();
    start_store = 1'b0;
    chk(name, "busy_start",  busy,     1);
    chk(name, "ready_start", in_ready, 1);
    sent     = 0;
    cyc      = 0;
    wr_cnt   = 0;
    exp_addr = base;
    while (sent < n && cyc < 4000) begin
      v        = toggle ? ((cyc % 2) == 0) : 1'b1;
      in_valid = v;
      in_data  = pat(sent);
      if (disturb && sent == 10) begin
        start_store      = 1'b1;
        Buffer_Select    = 4'b0111;
        Tiles_Control    = ~tc;
        Double_buffering = ~db;
      end else begin
        start_store = 1'b0;
      end
      acc = v && in_ready;
      tick();
      cyc++;
      if (acc) sent++;
      chk(name, "bram_en", bram_en, acc);
      if (bram_en === 1'b1) begin
        chk(name, "bram_addr",  bram_addr,  exp_addr[15:0]);
        chk(name, "bram_wdata", bram_wdata, pat(wr_cnt));
        chk(name, "bram_we",    bram_we,    1);
        wr_cnt++;
        exp_addr++;
      end
      chk(name, "store_done", store_done, (sent == n));
      chk(name, "busy",       busy,       1);
    end
    start_store = 1'b0;
    in_valid    = 1'b0;
    chk(name, "beats_accepted", sent,   n);
    chk(name, "writes",         wr_cnt, n);
    if (rac_done) reset_addr_counter = 1'b1;
    tick();
    reset_addr_counter = 1'b0;
    chk(name, "done_end",  store_done, 0);
    chk(name, "busy_end",  busy,       0);
    chk(name, "en_end",    bram_en,    0);
    chk(name, "ready_end", in_ready,   0);
    $display("tile %s sel=%b base=%0d beats=%0d writes=%0d cycles=%0d",
             name, sel, base, sent, wr_cnt, cyc);
  endtask

  task automatic pulse_rac();
    reset_addr_counter = 1'b1;
    tick();
    reset_addr_counter = 1'b0;
  endtask

  initial begin
    rst_n              = 1'b0;
    start_store        = 1'b0;
    reset_addr_counter = 1'b0;
    Buffer_Select      = 4'b0000;
    Tiles_Control      = 1'b0;
    Double_buffering   = 1'b0;
    in_valid           = 1'b0;
    in_data            = '0;

    repeat (3) tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // K buffer, 32-word tiles: tile_ptr 0 then 1.
    run_tile("A", 4'b0001, 1'b1, 1'b0, 32, 1'b0, 1'b0, 1'b0, 12288);
    // Second tile; pointer cleared during its DONE cycle (beats the increment).
    run_tile("B", 4'b0001, 1'b1, 1'b0, 32, 1'b0, 1'b0, 1'b1, 12320);
    run_tile("C", 4'b0001, 1'b1, 1'b0, 32, 1'b0, 1'b0, 1'b0, 12288);
    pulse_rac();

    // kTQ + double buffer, 512-word tile, 50% valid, mid-tile disturbances.
    run_tile("D", 4'b0011, 1'b0, 1'b1, 512, 1'b1, 1'b1, 1'b0, 12288);
    chk("D", "sel_err", sel_err, 0);
    pulse_rac();

    // Illegal code: base 0, sticky error.
    run_tile("E", 4'b1010, 1'b1, 1'b0, 32, 1'b0, 1'b0, 1'b0, 0);
    chk("E", "sel_err", sel_err, 1);
    // Q buffer with tile_ptr=1: base 32; error still latched.
    run_tile("F", 4'b0000, 1'b1, 1'b0, 32, 1'b0, 1'b0, 1'b0, 32);
    chk("F", "sel_err", sel_err, 1);

    // H buffer, 512-word tile at tile_ptr=2 (28672 + 1024), reset after 10 beats.
    Buffer_Select    = 4'b0101;
    Tiles_Control    = 1'b0;
    Double_buffering = 1'b0;
    start_store      = 1'b1;
    tick();
    start_store = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = pat(i);
      tick();
      chk("G", "bram_en",   bram_en,   1);
      chk("G", "bram_addr", bram_addr, 16'(29696 + i));
    end
    $display("tile G sel=0101 base=29696 beats=10 aborted by reset");
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("G_rst");
    tick();
    chk_reset_outputs("G_rst_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("G_after", "bram_en",  bram_en,  0);
      chk("G_after", "in_ready", in_ready, 0);
      chk("G_after", "busy",     busy,     0);
    end
    in_valid = 1'b0;

    // Fresh tile after reset: tile_ptr back to 0.
    run_tile("H", 4'b0101, 1'b1, 1'b0, 32, 1'b0, 1'b0, 1'b0, 28672);
    chk("H", "sel_err", sel_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_logic_gen.md
STORE_LOGIC_GEN -- requirements
Module: store_logic_gen

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, BRAM address width.
REQ-002 SHALL have parameter ORIGINAL_COLUMNS, default 768, matrix columns.
REQ-003 SHALL have parameter ORIGINAL_ROWS, default 512, matrix rows.
REQ-004 SHALL have parameter NUM_BITS, default 8, quantized element width.
REQ-005 SHALL have parameter DATA_WIDTH, default 256, BRAM word width; MAT_WORDS = ORIGINAL_COLUMNS*ORIGINAL_ROWS*NUM_BITS/DATA_WIDTH (12288 at defaults).
REQ-006 SHALL have parameter DB_OFFSET, default 4096, double-buffer address offset.
REQ-007 SHALL use one clock; reset is asynchronous and active-low: clk input 1 system clock; rst_n input 1 async active-low reset.
REQ-008 start_store input 1, pulse that begins storing one tile.
REQ-009 reset_addr_counter input 1, pulse that clears the tile pointer.
REQ-010 Buffer_Select input 4, destination buffer code.
REQ-011 Tiles_Control input 1, selects tile length: 1 -> 32 words, 0 -> 512 words.
REQ-012 Double_buffering input 1, adds DB_OFFSET to the destination base.
REQ-013 in_valid input 1, result word valid.
REQ-014 in_data input DATA_WIDTH, result word.
REQ-015 in_ready output 1, block accepts a word.
REQ-016 bram_addr output ADDR_WIDTH, BRAM write address.
REQ-017 bram_wdata output DATA_WIDTH, BRAM write data.
REQ-018 bram_en, bram_we outputs 1 each, BRAM port enable and write enable.
REQ-019 store_done output 1, one-cycle pulse at tile end.
REQ-020 busy output 1, high while a tile is in progress.
REQ-021 sel_err output 1, sticky flag for an illegal Buffer_Select value.

Function
REQ-022 FSM states SHALL be IDLE, STORING and DONE; IDLE->STORING on start_store; STORING->DONE on the cycle the last beat is accepted; DONE->IDLE unconditionally.
REQ-023 start_store outside IDLE SHALL be ignored.
REQ-024 On IDLE->STORING the block SHALL latch tile_len, and tile_base = base(Buffer_Select) + (Double_buffering ? DB_OFFSET : 0) + tile_ptr*tile_len, truncated to ADDR_WIDTH; mid-tile input changes SHALL have no effect.
REQ-025 Base map: 0000 Q=0; 0001 K=MAT_WORDS; 0010 V=2*MAT_WORDS; 0011 kTQ=8192; 0100 SV=20480; 0101 H=28672; 0110 FFN intermediate=0; 0111 O=49152.
REQ-026 Codes 1000-1111 SHALL use base 0, set sel_err (cleared only by reset), and still store the tile.
REQ-027 in_ready SHALL be 1 only in STORING; a beat is accepted when in_valid && in_ready.
REQ-028 Per accepted beat, the next cycle SHALL have bram_en=bram_we=1, bram_addr=tile_base+beat_cnt, bram_wdata=in_data (registered, latency 1); otherwise bram_en=bram_we=0, and addr/wdata hold.
REQ-029 beat_cnt (10-bit) SHALL increment only on an accepted beat, clear when entering STORING, and the last beat is beat_cnt==tile_len-1.
REQ-030 in_valid low SHALL stall without a write; there is no timeout.
REQ-031 busy SHALL be 1 in STORING and DONE; store_done SHALL be 1 only in DONE, i.e. the cycle the last write appears on the BRAM port.
REQ-032 tile_ptr (10-bit) SHALL increment in DONE and wrap 1023->0.
REQ-033 reset_addr_counter SHALL clear tile_ptr in any state, with priority over the DONE increment; it SHALL not alter tile_base of the tile in progress.

Reset
REQ-034 On rst_n low, regardless of the state of a tile in progress: state=IDLE, tile_ptr=0, beat_cnt=0, bram_addr=0, bram_wdata=0, bram_en=bram_we=0, in_ready=0, store_done=0, busy=0, sel_err=0.
REQ-035 A tile interrupted by reset SHALL be abandoned, with no further writes.

Verification
REQ-036 Select 0001, Tiles_Control=1, DB=0, 32 back-to-back beats -> writes at addr 12288..12319, one per cycle, store_done 1 cycle after the last beat, tile_ptr=1.
REQ-037 Second tile, same setup -> addr 12320..12351; then reset_addr_counter pulsed during DONE -> tile_ptr=0, and the next tile starts at 12288.
REQ-038 Select 0011, Tiles_Control=0, DB=1, in_valid toggling 50% -> exactly 512 writes at addr 12288..12799, contiguous with no gaps or duplicates, busy high throughout.
REQ-039 start_store pulsed mid-tile, and Buffer_Select changed mid-tile -> ignored, addresses unchanged.
REQ-040 Select 1010 -> sel_err=1 and writes from addr 0; sel_err stays 1 until rst_n.
REQ-041 rst_n asserted after 10 beats -> all outputs reset values, and no write after deassertion until a new start_store.
